sccb_wr_master: RTL and testbench



---
 rtl/sccb_wr_master_pkg.sv | 18 +
 rtl/sccb_wr_master_if.sv | 27 ++
 rtl/sccb_wr_master_qtick.sv | 35 +++
 rtl/sccb_wr_master.sv | 161 ++++++++++++++++
 tb/tb_sccb_wr_master.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_wr_master_pkg.sv
// Shared camera-control definitions for the SCCB write master: FSM states,
// default divider and frame sizing.
package cam_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BIT   = 3'd2,
      ACKS  = 3'd3,
      STOP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [7:0] SCCB_DEV_WR = 8'h78;
   localparam int         QDIV_DEF    = 62;
   localparam int         NBYTES_DEF  = 4;

endpackage

// File: rtl/sccb_wr_master_if.sv
// Sequencer handshake plus SCCB pad signals of the write master, bundled so the
// master and the sequencer/pad side see matching directions.
interface sccb_wr_master_if
   import cam_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF
);
   logic [8*NBYTES-1:0] cfg_data;
   logic                i2c_req;
   logic                i2c_ack;
   logic                nack;
   logic                busy;
   logic                sclk;
   logic                sda_out;
   logic                sda_oe;
   logic                sda_in;

   modport master (
      input  cfg_data, i2c_req, sda_in,
      output i2c_ack, nack, busy, sclk, sda_out, sda_oe
   );

   modport slave (
      output cfg_data, i2c_req, sda_in,
      input  i2c_ack, nack, busy, sclk, sda_out, sda_oe
   );
endinterface

// File: rtl/sccb_wr_master_qtick.sv
// Quarter-period tick divider for SCL generation: a one-cycle tick every QDIV
// clocks and a 2-bit quarter phase, both held at zero while disabled.
module sccb_qtick #(
   parameter int QDIV = 62
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   output logic       o_qtick,
   output logic [1:0] o_qphase
);
   localparam int CW = $clog2(QDIV);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_qphase;

   assign o_qtick  = i_en && (r_cnt == CW'(QDIV - 1));
   assign o_qphase = r_qphase;

   // divider count and quarter phase; cleared whenever the master is idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_qphase <= 2'd0;
      end else if (!i_en) begin
         r_cnt    <= '0;
         r_qphase <= 2'd0;
      end else if (o_qtick) begin
         r_cnt    <= '0;
         r_qphase <= r_qphase + 2'd1;
      end else begin
         r_cnt    <= r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/sccb_wr_master.sv
// SCCB/I2C write master: shifts out one multi-byte write frame (START, bytes
// with ACK slots, STOP) per accepted request and reports any NACK.
module sccb_wr_master
   import cam_pkg::*;
#(
   parameter int QDIV   = QDIV_DEF,
   parameter int NBYTES = NBYTES_DEF
) (
   input  logic             clk_25M,
   input  logic             rst_100,
   sccb_wr_master_if.master bus
);
   localparam int             SW        = 8 * NBYTES;
   localparam int             BW        = $clog2(NBYTES);
   localparam logic [BW-1:0]  LAST_BYTE = BW'(NBYTES - 1);

   state_t        r_state;
   logic [SW-1:0] r_shreg;
   logic [BW-1:0] r_byte_cnt;
   logic [2:0]    r_bit_cnt;
   logic          r_sclk;
   logic          r_sda_out;
   logic          r_sda_oe;
   logic          r_ack;
   logic          r_nack;
   logic          r_busy;

   logic          w_run;
   logic          w_qtick;
   logic [1:0]    w_qphase;

   assign w_run = (r_state != IDLE);

   sccb_qtick #(.QDIV(QDIV)) u_qtick (
      .clk      (clk_25M),
      .rst_n    (rst_100),
      .i_en     (w_run),
      .o_qtick  (w_qtick),
      .o_qphase (w_qphase)
   );

   assign bus.sclk    = r_sclk;
   assign bus.sda_out = r_sda_out;
   assign bus.sda_oe  = r_sda_oe;
   assign bus.i2c_ack = r_ack;
   assign bus.nack    = r_nack;
   assign bus.busy    = r_busy;

   // frame sequencer: every action lands on the tick that ends its quarter
   always_ff @(posedge clk_25M) begin
      if (!rst_100) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_byte_cnt <= '0;
         r_bit_cnt  <= 3'd7;
         r_sclk     <= 1'b1;
         r_sda_out  <= 1'b1;
         r_sda_oe   <= 1'b1;
         r_ack      <= 1'b0;
         r_nack     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i2c_req && !r_ack) begin
                  r_shreg    <= bus.cfg_data;
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= 3'd7;
                  r_nack     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_qtick) begin
                  case (w_qphase)
                     2'd0: begin
                        r_sda_out <= 1'b1;
                        r_sda_oe  <= 1'b1;
                     end
                     2'd1: r_sda_out <= 1'b0;
                     2'd2: r_sclk    <= 1'b0;
                     2'd3: r_state   <= BIT;
                     default: r_state <= IDLE;
                  endcase
               end
            end
            BIT: begin
               if (w_qtick) begin
                  case (w_qphase)
                     2'd0: r_sda_out <= r_shreg[SW-1];
                     2'd1: r_sclk    <= 1'b1;
                     2'd2: r_sclk    <= 1'b1;
                     2'd3: begin
                        r_sclk  <= 1'b0;
                        r_shreg <= {r_shreg[SW-2:0], 1'b0};
                        if (r_bit_cnt == 3'd0) begin
                           r_state <= ACKS;
                        end else begin
                           r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                     end
                     default: r_state <= IDLE;
                  endcase
               end
            end
            ACKS: begin
               // a NACK is only recorded; the frame always runs to its STOP
               if (w_qtick) begin
                  case (w_qphase)
                     2'd0: r_sda_oe <= 1'b0;
                     2'd1: r_sclk   <= 1'b1;
                     2'd2: r_nack   <= r_nack | bus.sda_in;
                     2'd3: begin
                        r_sclk   <= 1'b0;
                        r_sda_oe <= 1'b1;
                        if (r_byte_cnt == LAST_BYTE) begin
                           r_state <= STOP;
                        end else begin
                           r_byte_cnt <= r_byte_cnt + BW'(1);
                           r_bit_cnt  <= 3'd7;
                           r_state    <= BIT;
                        end
                     end
                     default: r_state <= IDLE;
                  endcase
               end
            end
            STOP: begin
               if (w_qtick) begin
                  case (w_qphase)
                     2'd0: r_sda_out <= 1'b0;
                     2'd1: r_sclk    <= 1'b1;
                     2'd2: r_sda_out <= 1'b1;
                     2'd3: begin
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                     end
                     default: r_state <= IDLE;
                  endcase
               end
            end
            DONE: begin
               if (!bus.i2c_req) begin
                  r_ack   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_sclk    <= 1'b1;
               r_sda_out <= 1'b1;
               r_sda_oe  <= 1'b1;
               r_ack     <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sccb_wr_master.sv
// Bench for sccb_wr_master: a quarter-timeline reference model checked every
// cycle, a protocol decoder of the SCL/SDA lines, and directed handshake cases.
module tb_sccb_wr_master;
   localparam int QDIV  = 8;
   localparam int NB    = 4;
   localparam int FRAME = 152 * QDIV;

   logic clk_25M = 1'b0;
   logic rst_100;
   always #5 clk_25M = ~clk_25M;

   sccb_wr_master_if #(.NBYTES(NB)) bus ();

   sccb_wr_master #(.QDIV(QDIV), .NBYTES(NB)) dut (
      .clk_25M (clk_25M),
      .rst_100 (rst_100),
      .bus     (bus)
   );

   int          n_vec = 0;
   int          n_mis = 0;
   logic [3:0]  g_mask;

   logic        m_active, m_ack, m_nack;
   int          m_cyc;
   logic [31:0] m_word;

   logic        p_sclk, p_line, after_stop;
   int          mon_bits, n_start, n_stop, gap, gap_low, last_gap, last_low;
   logic [7:0]  mon_byte, mon_acks;
   logic [7:0]  mon_bytes [$];

   // {sclk, sda_out, sda_oe, sda_care} after c completed quarters of a frame
   function automatic logic [3:0] exp_line(int c, logic [31:0] w);
      int q, s, p, b, i;
      logic hi;
      if (c <= 1) return 4'b1111;
      if (c == 2) return 4'b1011;
      if (c <= 4) return 4'b0011;
      if (c <= 148) begin
         q  = c - 5;
         s  = q / 4;
         p  = q % 4;
         b  = s / 9;
         i  = s % 9;
         hi = (p == 1) || (p == 2);
         if (i < 8) return {hi, w[31 - 8*b - i], 1'b1, 1'b1};
         if (p == 3) return {1'b0, w[24 - 8*b], 1'b1, 1'b1};
         return {hi, 1'b0, 1'b0, 1'b0};
      end
      if (c == 149) return 4'b0011;
      if (c == 150) return 4'b1011;
      return 4'b1111;
   endfunction

   function automatic bit is_ack_sample(int c);
      return (c >= 5) && (c <= 148) && (((c - 5) % 4) == 2) && ((((c - 5) / 4) % 9) == 8);
   endfunction

   function automatic logic slave_bit(int c, logic [3:0] mask);
      int s;
      if (c >= 4 && c <= 147) begin
         s = (c - 4) / 4;
         if ((s % 9) == 8) return mask[s / 9];
      end
      return 1'b1;
   endfunction

   // reference model: accept, fixed-length frame, ack held until request drops
   always @(posedge clk_25M) begin
      if (!rst_100) begin
         m_active <= 1'b0;
         m_ack    <= 1'b0;
         m_nack   <= 1'b0;
         m_cyc    <= 0;
      end else if (m_active) begin
         if (((m_cyc + 1) % QDIV == 0) && is_ack_sample((m_cyc + 1) / QDIV))
            m_nack <= m_nack | bus.sda_in;
         if (m_cyc + 1 == FRAME) begin
            m_active <= 1'b0;
            m_ack    <= 1'b1;
         end
         m_cyc <= m_cyc + 1;
      end else if (m_ack) begin
         if (!bus.i2c_req) m_ack <= 1'b0;
      end else if (bus.i2c_req) begin
         m_active <= 1'b1;
         m_cyc    <= 0;
         m_word   <= bus.cfg_data;
         m_nack   <= 1'b0;
      end
   end

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic clear_mon();
      mon_bytes.delete();
      mon_bits   = 0;
      mon_byte   = 8'd0;
      mon_acks   = 8'd0;
      n_start    = 0;
      n_stop     = 0;
      after_stop = 1'b0;
      gap        = 0;
      gap_low    = 0;
      last_gap   = 0;
      last_low   = 0;
      p_sclk     = 1'b1;
      p_line     = 1'b1;
   endtask

   // one clock: compare against the model, decode the line, drive the slave
   task automatic step();
      logic [5:0] got, want;
      logic [3:0] e;
      logic       line;
      @(negedge clk_25M);
      e    = m_active ? exp_line(m_cyc / QDIV, m_word) : 4'b1111;
      want = {m_ack, m_active, m_nack & m_ack, e[3], e[1], e[2] & e[0]};
      got  = {bus.i2c_ack, bus.busy, bus.nack & m_ack, bus.sclk, bus.sda_oe, bus.sda_out & e[0]};
      n_vec++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL cycle @%0t ack,busy,nack,scl,oe,sda: got %b want %b", $time, got, want);
      end
      line = bus.sda_oe ? bus.sda_out : bus.sda_in;
      if (p_sclk && bus.sclk && p_line && !line) begin
         n_start++;
         mon_bits = 0;
         if (after_stop) begin
            last_gap = gap;
            last_low = gap_low;
         end
         after_stop = 1'b0;
      end
      if (p_sclk && bus.sclk && !p_line && line) begin
         n_stop++;
         after_stop = 1'b1;
         gap        = 0;
         gap_low    = 0;
      end else if (after_stop) begin
         gap++;
         if (!bus.sclk) gap_low++;
      end
      if (!p_sclk && bus.sclk) begin
         if (mon_bits < 8) begin
            mon_byte = {mon_byte[6:0], line};
            mon_bits++;
         end else begin
            mon_bytes.push_back(mon_byte);
            mon_acks = {mon_acks[6:0], line};
            mon_bits = 0;
         end
      end
      p_sclk = bus.sclk;
      p_line = line;
      bus.sda_in = m_active ? slave_bit(m_cyc / QDIV, g_mask) : 1'b1;
   endtask

   function automatic logic [63:0] packq();
      logic [63:0] r = 64'd0;
      foreach (mon_bytes[i]) r = {r[55:0], mon_bytes[i]};
      return r;
   endfunction

   task automatic wait_busy(string nm);
      int n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk(nm, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_ack(logic val, int lim, string nm, output int n);
      n = 0;
      while (bus.i2c_ack !== val && n < lim) begin
         step();
         n++;
      end
      chk(nm, 64'(bus.i2c_ack), 64'(val));
   endtask

   task automatic start_req(logic [31:0] w, logic [3:0] mask);
      g_mask        = mask;
      bus.cfg_data  = w;
      bus.i2c_req   = 1'b1;
   endtask

   task automatic end_req(string nm);
      int n;
      bus.i2c_req = 1'b0;
      wait_ack(1'b0, 10, nm, n);
   endtask

   initial begin
      int n, cnt;
      rst_100      = 1'b0;
      bus.i2c_req  = 1'b0;
      bus.cfg_data = 32'd0;
      bus.sda_in   = 1'b1;
      g_mask       = 4'd0;
      clear_mon();
      repeat (3) step();
      chk("reset_outputs", 64'({bus.sclk, bus.sda_out, bus.sda_oe, bus.i2c_ack, bus.nack, bus.busy}), 64'(6'b111000));
      rst_100 = 1'b1;
      repeat (2) step();

      // plain frame, cfg_data disturbed after accept
      clear_mon();
      start_req(32'h7830_0882, 4'b0000);
      wait_busy("t1_busy");
      bus.cfg_data = 32'hDEAD_BEEF;
      wait_ack(1'b1, 2000, "t1_ack", n);
      chk("t1_latency", 64'(n), 64'd1216);
      chk("t1_nack", 64'(bus.nack), 64'd0);
      chk("t1_bytes", packq(), 64'h7830_0882);
      chk("t1_nbytes", 64'(mon_bytes.size()), 64'd4);
      chk("t1_acks", 64'(mon_acks[3:0]), 64'h0);
      chk("t1_start_stop", 64'({n_start[3:0], n_stop[3:0]}), 64'h11);
      end_req("t1_drop");

      // NACK on byte 2 only
      clear_mon();
      start_req(32'h7812_3456, 4'b0100);
      wait_busy("t2_busy");
      wait_ack(1'b1, 2000, "t2_ack", n);
      chk("t2_nack", 64'(bus.nack), 64'd1);
      chk("t2_bytes", packq(), 64'h7812_3456);
      chk("t2_acks", 64'(mon_acks[3:0]), 64'h2);
      chk("t2_stop", 64'(n_stop), 64'd1);
      end_req("t2_drop");

      // request held high long after completion
      clear_mon();
      start_req(32'h7830_0A5C, 4'b0000);
      wait_busy("t3_busy");
      chk("t3_nack_cleared", 64'(bus.nack), 64'd0);
      wait_ack(1'b1, 2000, "t3_ack", n);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.i2c_ack && !bus.busy && bus.sclk) cnt++;
      end
      chk("t3_ack_held", 64'(cnt), 64'd100);
      chk("t3_one_frame", 64'(n_start), 64'd1);
      bus.i2c_req = 1'b0;
      step();
      chk("t3_ack_clear", 64'({bus.i2c_ack, bus.busy}), 64'd0);

      // request dropped at byte 1 bit 5
      clear_mon();
      start_req(32'h7830_1234, 4'b0000);
      wait_busy("t4_busy");
      repeat (490) step();
      bus.i2c_req = 1'b0;
      wait_ack(1'b1, 2000, "t4_ack", n);
      cnt = 1;
      repeat (300) begin
         step();
         if (bus.i2c_ack) cnt++;
      end
      chk("t4_ack_pulse", 64'(cnt), 64'd1);
      chk("t4_bytes", packq(), 64'h7830_1234);
      chk("t4_one_frame", 64'(n_start), 64'd1);

      // reset during the data byte, then a clean frame
      clear_mon();
      start_req(32'h7830_0AA5, 4'b0000);
      wait_busy("t5_busy");
      repeat (1000) step();
      rst_100     = 1'b0;
      bus.i2c_req = 1'b0;
      step();
      chk("t5_reset_idle", 64'({bus.sclk, bus.sda_out, bus.sda_oe, bus.busy, bus.i2c_ack}), 64'(5'b11100));
      step();
      rst_100 = 1'b1;
      repeat (2) step();
      clear_mon();
      start_req(32'h7830_0C3C, 4'b0000);
      wait_busy("t5_busy2");
      wait_ack(1'b1, 2000, "t5_ack", n);
      chk("t5_bytes", packq(), 64'h7830_0C3C);
      chk("t5_start_stop", 64'({n_start[3:0], n_stop[3:0]}), 64'h11);
      end_req("t5_drop");

      // back-to-back sequencer handshakes
      clear_mon();
      start_req(32'h7831_0311, 4'b0000);
      wait_busy("t6_busy_a");
      wait_ack(1'b1, 2000, "t6_ack_a", n);
      end_req("t6_drop_a");
      start_req(32'h7830_17FF, 4'b0000);
      wait_busy("t6_busy_b");
      wait_ack(1'b1, 2000, "t6_ack_b", n);
      chk("t6_bytes", packq(), 64'h7831_0311_7830_17FF);
      chk("t6_nbytes", 64'(mon_bytes.size()), 64'd8);
      chk("t6_start_stop", 64'({n_start[3:0], n_stop[3:0]}), 64'h22);
      chk("t6_gap_ok", 64'((last_gap >= 1) && (last_low == 0)), 64'd1);
      end_req("t6_drop_b");
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
